// File: rtl/pulse_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_gen_pkg
//  Purpose  : Shared types and constants for the pulse generator / capture path
//  Revision : 1.0 - initial release
// ============================================================================
package pulse_gen_pkg;

   // Bins per clk300 cycle; also the width of the serializer word.
   localparam int SER_W_DEF = 16;

   // Request sequencing states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DELAY = 2'd1,
      EMIT  = 2'd2
   } pg_state_t;

endpackage
`default_nettype wire

// File: rtl/pulse_gen_mask.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_gen_mask
//  Purpose  : Combinational contiguous bit mask: i_count ones starting at bit
//             i_start. Caller guarantees i_start + i_count <= SER_W.
//  Revision : 1.0 - initial release
// ============================================================================
module pulse_gen_mask
   import pulse_gen_pkg::*;
#(
   parameter int SER_W = SER_W_DEF,
   parameter int PT_W  = $clog2(SER_W)
) (
   input  logic [PT_W-1:0]  i_start,
   input  logic [PT_W:0]    i_count,
   output logic [SER_W-1:0] o_mask
);

   logic [SER_W-1:0] w_ones;

   // Low i_count bits set (a shift by SER_W clears everything, giving all ones),
   // then moved up to the start bin.
   always_comb begin
      w_ones = ~({SER_W{1'b1}} << i_count);
      o_mask = w_ones << i_start;
   end

endmodule
`default_nettype wire

// File: rtl/pulse_gen_ser.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_gen_ser
//  Purpose  : Turns timed pulse requests (coarse delay, fine phase, width in
//             bins) into SER_W-bit words for an LSB-first output serializer.
//  Options  : PULSE_GEN_COUNT_EN - adds pulse_cnt, a count of completed
//             non-null requests.
//  Revision : 1.0 - initial release
// ============================================================================
module pulse_gen_ser
   import pulse_gen_pkg::*;
#(
   parameter int SER_W   = SER_W_DEF,
   parameter int PT_W    = $clog2(SER_W),
   parameter int WIDTH_W = 8,
   parameter int DELAY_W = 8
) (
   input  logic               clk300,
   input  logic               rst_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [PT_W-1:0]    req_ptime,
   input  logic [WIDTH_W-1:0] req_width,
   input  logic [DELAY_W-1:0] req_delay,
   output logic [SER_W-1:0]   ser_word,
`ifdef PULSE_GEN_COUNT_EN
   output logic [15:0]        pulse_cnt,
`endif
   output logic               busy,
   output logic               done
);

   localparam int REM_W = WIDTH_W + 1;
   localparam int CNT_W = PT_W + 1;

   pg_state_t          r_state;
   logic [PT_W-1:0]    r_start;
   logic [REM_W-1:0]   r_rem;
   logic [DELAY_W-1:0] r_dly;
   logic [SER_W-1:0]   r_word;
   logic               r_ready;
   logic               r_busy;
   logic               r_done;

   logic               w_accept;
   logic [CNT_W-1:0]   w_room;
   logic [REM_W-1:0]   w_room_ext;
   logic [CNT_W-1:0]   w_count;
   logic [REM_W-1:0]   w_count_ext;
   logic [SER_W-1:0]   w_mask;

   assign w_accept    = req_valid & r_ready;

   // Bins left in the current word, and how many of them this word carries.
   assign w_room      = CNT_W'(SER_W) - {1'b0, r_start};
   assign w_room_ext  = {{(REM_W-CNT_W){1'b0}}, w_room};
   assign w_count     = (r_rem < w_room_ext) ? r_rem[CNT_W-1:0] : w_room;
   assign w_count_ext = {{(REM_W-CNT_W){1'b0}}, w_count};

   pulse_gen_mask #(
      .SER_W (SER_W),
      .PT_W  (PT_W)
   ) u_mask (
      .i_start (r_start),
      .i_count (w_count),
      .o_mask  (w_mask)
   );

   // Request sequencer: capture on accept, count down the delay, emit words,
   // then one trailing cycle that signals done with an empty word.
   always_ff @(posedge clk300 or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_start <= '0;
         r_rem   <= '0;
         r_dly   <= '0;
         r_word  <= '0;
         r_ready <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               r_word  <= '0;
               r_ready <= 1'b1;
               if (w_accept) begin
                  r_start <= req_ptime;
                  r_rem   <= {1'b0, req_width};
                  r_dly   <= req_delay;
                  r_ready <= 1'b0;
                  r_busy  <= 1'b1;
                  // A null request skips the delay and finishes next cycle.
                  if ((req_width != '0) && (req_delay != '0)) begin
                     r_state <= DELAY;
                  end else begin
                     r_state <= EMIT;
                  end
               end
            end
            DELAY: begin
               r_word <= '0;
               r_dly  <= r_dly - DELAY_W'(1);
               if (r_dly == DELAY_W'(1)) begin
                  r_state <= EMIT;
               end
            end
            EMIT: begin
               if (r_rem == '0) begin
                  r_word  <= '0;
                  r_done  <= 1'b1;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else begin
                  // Later words always start at bin 0 so the pulse stays contiguous.
                  r_word  <= w_mask;
                  r_rem   <= r_rem - w_count_ext;
                  r_start <= '0;
               end
            end
            default: begin
               r_word  <= '0;
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign req_ready = r_ready;
   assign ser_word  = r_word;
   assign busy      = r_busy;
   assign done      = r_done;

`ifdef PULSE_GEN_COUNT_EN
   logic        r_nonnull;
   logic [15:0] r_cnt;

   // Count requests that complete with at least one pulse bin; wraps naturally.
   always_ff @(posedge clk300 or negedge rst_n) begin
      if (!rst_n) begin
         r_nonnull <= 1'b0;
         r_cnt     <= '0;
      end else begin
         if (w_accept) begin
            r_nonnull <= |req_width;
         end
         if ((r_state == EMIT) && (r_rem == '0) && r_nonnull) begin
            r_cnt <= r_cnt + 16'd1;
         end
      end
   end

   assign pulse_cnt = r_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pulse_gen_ser.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pulse_gen_ser
//  Purpose  : Randomized scoreboard bench for pulse_gen_ser. Expected words
//             come from a bin-level model of each pulse (absolute bin range
//             cut into SER_W-bin words).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_gen_ser;

   localparam int SER_W = 16;

   logic        clk300    = 1'b0;
   logic        rst_n     = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [3:0]  req_ptime = '0;
   logic [7:0]  req_width = '0;
   logic [7:0]  req_delay = '0;
   logic [15:0] ser_word;
   logic        busy;
   logic        done;
`ifdef PULSE_GEN_COUNT_EN
   logic [15:0] pulse_cnt;
   int          model_cnt = 0;
`endif

   pulse_gen_ser dut (
      .clk300    (clk300),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_ptime (req_ptime),
      .req_width (req_width),
      .req_delay (req_delay),
      .ser_word  (ser_word),
`ifdef PULSE_GEN_COUNT_EN
      .pulse_cnt (pulse_cnt),
`endif
      .busy      (busy),
      .done      (done)
   );

   always #5 clk300 = ~clk300;

   typedef struct {
      logic [15:0] word;
      bit          edone;
      bit          chk;
      bit          ebusy;
      bit          erdy;
      bit          nn;
   } exp_t;

   exp_t q[$];
   int   errors    = 0;
   int   checks    = 0;
   int   cyc       = 0;
   int   next_free = 0;
   bit   mon_en    = 1'b0;

   always @(posedge clk300) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(logic [15:0] w, bit d, bit c, bit b, bit r, bit n);
      exp_t x;
      x.word = w; x.edone = d; x.chk = c; x.ebusy = b; x.erdy = r; x.nn = n;
      return x;
   endfunction

   // Expected per-cycle outputs from the cycle after accept edge e onward.
   task automatic push_model(input int p, input int w, input int d, input int e);
      int          nw;
      logic [15:0] wd;
      q.push_back(mk(16'h0, 1'b0, (w > 0), 1'b1, 1'b0, 1'b0));
      if (w == 0) begin
         q.push_back(mk(16'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
         next_free = e + 2;
      end else begin
         for (int k = 0; k < d; k++) q.push_back(mk(16'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
         nw = (p + w + SER_W - 1) / SER_W;
         for (int k = 0; k < nw; k++) begin
            for (int b = 0; b < SER_W; b++) begin
               wd[b] = ((k * SER_W + b) >= p) && ((k * SER_W + b) < (p + w));
            end
            q.push_back(mk(wd, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
         end
         q.push_back(mk(16'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1));
         next_free = e + d + nw + 2;
      end
   endtask

   // One cycle of stimulus, called at posedge+2; returns whether the model
   // expects the DUT to accept at the coming edge.
   task automatic step(input bit v, input int p, input int w, input int d, output bit acc);
      int e;
      req_valid = v;
      req_ptime = p[3:0];
      req_width = w[7:0];
      req_delay = d[7:0];
      e         = cyc + 1;
      acc       = v && (e >= next_free);
      @(posedge clk300);
      if (acc) push_model(p, w, d, e);
      #2;
      req_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      bit junk;
      repeat (n) step(1'b0, 0, 0, 0, junk);
   endtask

   // Holds req_valid with junk fields while busy, then presents the request.
   task automatic issue(input int p, input int w, input int d);
      bit acc  = 1'b0;
      bit junk;
      int guard = 0;
      while (!acc && guard < 2000) begin
         if (cyc + 1 < next_free)
            step(1'b1, $urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 255), junk);
         else
            step(1'b1, p, w, d, acc);
         guard++;
      end
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL issue_timeout: request p=%0d w=%0d d=%0d not accepted", p, w, d);
      end
   endtask

   task automatic drain();
      int g = 0;
      while (q.size() > 0 && g < 3000) begin
         idle(1);
         g++;
      end
      if (q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d entries left", q.size());
      end
   endtask

   // Monitor: compares every cycle against the scoreboard (idle when empty).
   always @(negedge clk300) begin
      exp_t x;
      if (mon_en) begin
         if (q.size() > 0) x = q.pop_front();
         else              x = mk(16'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
         check("ser_word", ser_word, x.word);
         check("done", done, x.edone);
         if (x.chk) begin
            check("busy", busy, x.ebusy);
            check("req_ready", req_ready, x.erdy);
         end
`ifdef PULSE_GEN_COUNT_EN
         if (x.nn) model_cnt = (model_cnt + 1) & 16'hFFFF;
         check("pulse_cnt", pulse_cnt, model_cnt);
`endif
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int p, w, d, sel;

      // Reset state held for three cycles.
      repeat (3) begin
         @(negedge clk300);
         check("rst_word", ser_word, 16'h0);
         check("rst_ready", req_ready, 1'b0);
         check("rst_busy", busy, 1'b0);
         check("rst_done", done, 1'b0);
      end
      @(posedge clk300); #2;
      rst_n = 1'b1;
      @(posedge clk300); #2;
      check("ready_after_rst", req_ready, 1'b1);
      next_free = cyc + 1;
      mon_en    = 1'b1;

      // Directed cases.
      issue(3, 4, 0);
      issue(14, 5, 2);
      issue(0, 40, 0);
      issue(5, 0, 7);
      issue(15, 1, 0);
      issue(0, 16, 0);
      issue(0, 255, 1);
      issue(15, 255, 0);
      issue(1, 15, 0);

      // Randomized requests with occasional idle gaps.
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
         p   = $urandom_range(0, 15);
         sel = $urandom_range(0, 9);
         w   = (sel == 0) ? 0 : (sel < 6) ? $urandom_range(1, 20) : $urandom_range(21, 255);
         d   = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 6);
         issue(p, w, d);
      end
      drain();

      // Reset in the middle of a long pulse: output clears at once, no done.
      issue(0, 200, 0);
      idle(2);
      check("pre_abort_word", ser_word, 16'hFFFF);
      mon_en = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_word", ser_word, 16'h0);
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      q.delete();
`ifdef PULSE_GEN_COUNT_EN
      model_cnt = 0;
`endif
      repeat (2) begin
         @(negedge clk300);
         check("abort_hold_done", done, 1'b0);
         check("abort_hold_ready", req_ready, 1'b0);
      end
      @(posedge clk300); #2;
      rst_n = 1'b1;
      @(posedge clk300); #2;
      check("ready_after_abort", req_ready, 1'b1);
      next_free = cyc + 1;
      mon_en    = 1'b1;
      idle(4);
      issue(2, 3, 0);
      issue(7, 0, 3);
      issue(9, 30, 3);
      drain();
      idle(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
